// File: rtl/mod_add_pipe_pkg.sv
// Shared types and defaults for the pipelined modular adder.
package mod_add_pipe_pkg;

    localparam int unsigned DATA_W = 64;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] q;
    } beat_t;

    typedef struct packed {
        logic [DATA_W-1:0] sum;
        logic              err;
    } result_t;

endpackage

// File: rtl/mod_add_pipe_mod_add.sv
// Combinational reduce step: folds a W+1 bit sum back into [0, q) with one conditional subtract.
module mod_add
    import mod_add_pipe_pkg::*;
#(
    parameter int unsigned W = DATA_W
) (
    input  logic [W:0]   sum,
    input  logic [W:0]   q,
    output logic [W-1:0] red
);

    logic [W-1:0] diff;

    // Only the low W bits of the difference are ever kept, so subtract at W bits.
    assign diff = sum[W-1:0] - q[W-1:0];
    assign red  = (sum >= q) ? diff : sum[W-1:0];

endmodule

// File: rtl/mod_add_pipe.sv
// Two-stage streaming (a + b) mod q with valid/ready on both sides and a per-beat range flag.
module mod_add_pipe
    import mod_add_pipe_pkg::*;
#(
    parameter int unsigned W = DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [W-1:0] in_q,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_err
);

    // A beat moves when valid && ready; ready never depends on valid, only on downstream state.
    logic         adv1;
    logic         adv2;
    logic         in_fire;

    logic         s1_valid_q, s1_valid_d;
    logic [W:0]   sum1_q, sum1_d;
    logic [W:0]   q1_q, q1_d;
    logic         err1_q, err1_d;

    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_sum_q, out_sum_d;
    logic         out_err_q, out_err_d;

    logic [W-1:0] reduced;

    assign adv2    = !out_valid_q || out_ready;
    assign adv1    = !s1_valid_q || adv2;
    assign in_fire = in_valid && adv1;

    mod_add #(.W(W)) u_reduce (
        .sum (sum1_q),
        .q   (q1_q),
        .red (reduced)
    );

    always_comb begin
        s1_valid_d  = s1_valid_q;
        sum1_d      = sum1_q;
        q1_d        = q1_q;
        err1_d      = err1_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_err_d   = out_err_q;

        if (adv1) begin
            s1_valid_d = in_fire;
            if (in_fire) begin
                // Keep the carry into bit W so the compare in stage 2 sees the true sum.
                sum1_d = {1'b0, in_a} + {1'b0, in_b};
                q1_d   = {1'b0, in_q};
                err1_d = (in_a >= in_q) || (in_b >= in_q) || (in_q == '0);
            end
        end

        if (adv2) begin
            out_valid_d = s1_valid_q;
            out_sum_d   = reduced;
            out_err_d   = err1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            sum1_q      <= '0;
            q1_q        <= '0;
            err1_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            sum1_q      <= sum1_d;
            q1_q        <= q1_d;
            err1_q      <= err1_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_err_q   <= out_err_d;
        end
    end

    assign in_ready  = adv1;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_mod_add_pipe.sv
// Scoreboard bench for mod_add_pipe: expected {err,sum} pushed on input transfer, checked on output transfer.
module tb_mod_add_pipe;
    import mod_add_pipe_pkg::*;

    localparam int unsigned W = DATA_W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [W-1:0] in_q = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_sum;
    logic         out_err;

    int total = 0;
    int bad   = 0;
    int acc_cnt = 0;
    int last_wait = 0;
    bit rand_bp = 1'b0;
    logic [W:0] exp_q[$];

    mod_add_pipe #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_q      (in_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_err   (out_err)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] q);
        logic [W:0]   s;
        logic         e;
        logic [W-1:0] r;
        s = {1'b0, a} + {1'b0, b};
        e = (a >= q) || (b >= q) || (q == '0);
        if (q == '0)
            r = s[W-1:0];
        else if (!e)
            r = W'(s % {1'b0, q});
        else
            r = (s >= {1'b0, q}) ? W'(s - {1'b0, q}) : s[W-1:0];
        return {e, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Leaves in_valid high; caller lowers it when the burst ends.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] q);
        int waits;
        waits = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_q = q;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits > 200) begin
                check("send_timeout", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
                in_valid = 1'b0;
                last_wait = waits;
                return;
            end
            tick();
        end
        exp_q.push_back(model(a, b, q));
        acc_cnt++;
        last_wait = waits;
        tick();
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check("drain", (W+1)'(exp_q.size()), '0);
    endtask

    // output scoreboard
    always @(negedge clk) begin
        logic [W:0] e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", {1'b0, out_sum}, '1);
            end else begin
                e = exp_q.pop_front();
                check("out_sum", {1'b0, out_sum}, {1'b0, e[W-1:0]});
                check("out_err", {{W{1'b0}}, out_err}, {{W{1'b0}}, e[W]});
            end
        end
    end

    initial begin
        logic [W-1:0] q, a, b;

        // reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {{W{1'b0}}, out_valid}, '0);
        check("rst_out_sum", {1'b0, out_sum}, '0);
        check("rst_out_err", {{W{1'b0}}, out_err}, '0);
        check("rst_in_ready", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
        tick();

        // simple beat and latency
        send(64'd5, 64'd3, 64'd17);
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_cycle1", {{W{1'b0}}, out_valid}, '0);
        @(negedge clk);
        check("lat_cycle2", {{W{1'b0}}, out_valid}, {{W{1'b0}}, 1'b1});
        tick();
        wait_drain();

        // back-to-back, in_ready must never stall
        send(64'd10, 64'd9, 64'd17);
        check("b2b_ready0", (W+1)'(last_wait), '0);
        send(64'd16, 64'd1, 64'd17);
        check("b2b_ready1", (W+1)'(last_wait), '0);
        send(64'd0, 64'd0, 64'd17);
        check("b2b_ready2", (W+1)'(last_wait), '0);
        in_valid = 1'b0;
        wait_drain();

        // carry into bit W
        send(64'hFFFF_FFFF_FFFF_FFC4, 64'hFFFF_FFFF_FFFF_FFC4, 64'hFFFF_FFFF_FFFF_FFC5);
        in_valid = 1'b0;
        wait_drain();

        // out-of-range operand and zero modulus
        send(64'd20, 64'd0, 64'd17);
        send(64'd7, 64'd9, 64'd0);
        in_valid = 1'b0;
        wait_drain();

        // backpressure: 4 beats into a stalled output
        out_ready = 1'b0;
        acc_cnt = 0;
        fork
            begin
                send(64'd1, 64'd2, 64'd17);
                send(64'd3, 64'd4, 64'd17);
                send(64'd15, 64'd15, 64'd17);
                send(64'd16, 64'd16, 64'd17);
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(negedge clk);
                repeat (3) begin
                    @(negedge clk);
                    check("stall_valid", {{W{1'b0}}, out_valid}, {{W{1'b0}}, 1'b1});
                    check("stall_hold", {1'b0, out_sum}, {1'b0, exp_q[0][W-1:0]});
                end
                check("stall_accepts", (W+1)'(acc_cnt), (W+1)'(2));
                check("stall_in_ready", {{W{1'b0}}, in_ready}, '0);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();

        // reset with two beats in flight
        out_ready = 1'b0;
        send(64'd1, 64'd1, 64'd17);
        send(64'd2, 64'd2, 64'd17);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_valid", {{W{1'b0}}, out_valid}, '0);
        check("mid_rst_sum", {1'b0, out_sum}, '0);
        check("mid_rst_ready", {{W{1'b0}}, in_ready}, {{W{1'b0}}, 1'b1});
        tick();
        out_ready = 1'b1;
        send(64'd1, 64'd2, 64'd17);
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_lat1", {{W{1'b0}}, out_valid}, '0);
        @(negedge clk);
        check("post_rst_lat2", {{W{1'b0}}, out_valid}, {{W{1'b0}}, 1'b1});
        tick();
        wait_drain();

        // random in-range traffic with random backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 40; i++) begin
            q = {$urandom, $urandom} | 64'd1;
            if (i % 4 == 0) q = 64'(($urandom_range(1, 60)));
            a = {$urandom, $urandom} % q;
            b = {$urandom, $urandom} % q;
            send(a, b, q);
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                tick();
            end
        end
        in_valid = 1'b0;
        rand_bp = 1'b0;
        wait_drain();

        check("final_queue", (W+1)'(exp_q.size()), '0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mod_add_pipe.md
Name: mod_add_pipe

Overview:
- Streaming, pipelined modular adder: out = (a + b) mod q.
- Additive counterpart to the combinational modular subtractor.
- Feeds the NTT butterfly and coefficient-wise add datapaths.
- Valid/ready handshake on both sides, one result per cycle sustained, full backpressure support, per-result range-error flag.

Parameters:
- W, 64, operand/modulus width in bits.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts beat this cycle.
- in_a  input  W  addend a.
- in_b  input  W  addend b.
- in_q  input  W  modulus q, per beat.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts result.
- out_sum  output  W  (a + b) mod q.
- out_err  output  1  operand out of range for this beat.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Reset: s1_valid=0, out_valid=0, out_sum=0, out_err=0, in_ready=1 on the first cycle after rst is sampled high.
  - Reset mid-operation discards all in-flight beats; no partial output.
- Pipeline: two register stages, latency 2 cycles from input transfer to out_valid with no stall.
- Stage 1 registers:
  - sum1 = {0,a} + {0,b} (W+1 bits)
  - q1 = {0,q}
  - err1 = (a >= q) || (b >= q) || (q == 0)
  - s1_valid
- Stage 2 registers:
  - out_sum = (sum1 >= q1) ? (sum1 - q1)[W-1:0] : sum1[W-1:0]
  - out_err = err1
  - out_valid
- Arithmetic:
  - The carry into bit W must be preserved; sum1 is never truncated before the compare.
  - Exact result is guaranteed only for a, b < q, q != 0.
  - When err1=1 the same formula is applied and out_err=1 flags the beat. No exception, no drop.
  - When q == 0, out_sum = low W bits of (a + b).
- Flow control:
  - adv2 = !out_valid || out_ready
  - adv1 = !s1_valid || adv2
  - in_ready = adv1 (combinational from out_ready; no ready→valid loop).
- Stall hold: when adv2=0, out_sum/out_err/out_valid hold stable. When adv1=0, stage-1 registers hold.
- Fill and drain:
  - Stage 1 loads on an input transfer.
  - Stage 1 bubbles (s1_valid←0) when adv1=1 and there is no input transfer.
  - Stage 2 loads from stage 1 when adv2=1; out_valid←s1_valid.
- Simultaneous events: an output transfer and an input transfer in the same cycle while full sustains 100% throughput.
- Capacity: max 2 beats in flight. Strict in-order delivery.
- Inputs are not required to be stable once in_ready=0; they are sampled only on transfer.

Decomposition:
- Shared package:
  - localparam W default 64.
  - Packed beat struct {a, b, q}.
  - Result struct {sum, err}.
- Sub-module mod_add, a combinational reduce step: inputs sum (W+1) and q (W+1); output W-bit reduced value. Instantiated in stage 2.
- Stage-1 adder and range check are inline.

Test Plan:
1. q=17, a=5, b=3, out_ready=1 → out_sum=8, out_err=0, out_valid exactly 2 cycles after transfer.
2. q=17, beats (10,9), (16,1), (0,0) back-to-back → 2, 0, 0 on consecutive cycles; in_ready stays 1 throughout.
3. q=0xFFFFFFFFFFFFFFC5, a=b=0xFFFFFFFFFFFFFFC4 → out_sum=0xFFFFFFFFFFFFFFC3 (bit-64 carry path).
4. q=17, a=20, b=0 → out_err=1, out_sum=3. Also q=0, a=7, b=9 → out_err=1, out_sum=16.
5. Backpressure: out_ready=0 for 6 cycles while in_valid=1 with 4 beats → in_ready drops after 2 accepts, out_sum held stable; release → all 4 results in order, no loss or duplicate.
6. Assert rst for 1 cycle with 2 beats in flight → next cycle out_valid=0, out_sum=0, in_ready=1; a subsequent beat (1,2,q=17) → 3 after 2 cycles.
